// File: rtl/tlda_sched_pkg.sv
// Shared constants and types for the two-requester TLDA scheduler.
// Command field layout, packed command width and the FSM state encoding.
package tlda_sched_pkg;

    localparam int CMD_W = 91;

    localparam int X0_LSB    = 0;
    localparam int X0_W      = 9;
    localparam int Y0_LSB    = 9;
    localparam int Y0_W      = 8;
    localparam int X1_LSB    = 17;
    localparam int X1_W      = 9;
    localparam int Y1_LSB    = 26;
    localparam int Y1_W      = 8;
    localparam int COLOR_LSB = 34;
    localparam int COLOR_W   = 16;
    localparam int THICK_LSB = 50;
    localparam int THICK_W   = 9;
    localparam int BASE_LSB  = 59;
    localparam int BASE_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_ARM       = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_COMPLETE  = 3'd4
    } state_e;

endpackage

// File: rtl/tlda_rr_arb2.sv
// Two-way round-robin grant. A lone requester always wins; on a tie the
// requester that was not granted last wins. last_grant resets to 1 so req0 wins first.
module tlda_rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant != 2'b00) begin
            last_grant_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/tlda_scheduler.sv
// Shares one thick-line-drawing accelerator between two command requesters:
// grant, latch the command, pulse go, wait for done (with watchdog), report back.
module tlda_scheduler
    import tlda_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CMD_W-1:0]  req0_cmd,
    output logic              req0_done,
    output logic              req0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CMD_W-1:0]  req1_cmd,
    output logic              req1_done,
    output logic              req1_err,
    input  logic              lda_done,
    output logic              lda_go,
    output logic [X0_W-1:0]   lda_x0,
    output logic [Y0_W-1:0]   lda_y0,
    output logic [X1_W-1:0]   lda_x1,
    output logic [Y1_W-1:0]   lda_y1,
    output logic [COLOR_W-1:0] lda_color,
    output logic [THICK_W-1:0] lda_thickness,
    output logic [BASE_W-1:0] lda_base_addr,
    output logic              busy,
    output logic              timeout_flag,
    input  logic              clear_err
);

    localparam logic [15:0] TIMEOUT_W = TIMEOUT_CYCLES[15:0];

    state_e           state_q, state_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;
    logic             owner_q, owner_d;
    logic             err_q, err_d;
    logic [15:0]      wd_q, wd_d;
    logic             tflag_q, tflag_d;

    logic [1:0]       grant;
    logic             accept;
    logic             expired;

    tlda_rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .enable (state_q == ST_IDLE),
        .valid  ({req1_valid, req0_valid}),
        .grant  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept     = grant[0] | grant[1];

    // Watchdog saturates at the limit, so the compare stays valid for any count.
    assign expired = (state_q == ST_WAIT_DONE) && !lda_done && (wd_q >= TIMEOUT_W);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            tflag_q <= tflag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (accept) state_d = ST_ISSUE;
            ST_ISSUE:     state_d = ST_ARM;
            ST_ARM:       state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (lda_done || expired) state_d = ST_COMPLETE;
            ST_COMPLETE:  state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_d   = cmd_q;
        owner_d = owner_q;
        err_d   = err_q;
        wd_d    = wd_q;
        tflag_d = tflag_q;
        if (accept) begin
            cmd_d   = grant[1] ? req1_cmd : req0_cmd;
            owner_d = grant[1];
            err_d   = 1'b0;
        end
        if (state_q == ST_ARM) begin
            wd_d = '0;
        end else if (state_q == ST_WAIT_DONE && !lda_done && !expired) begin
            wd_d = wd_q + 16'd1;
        end
        if (expired) begin
            err_d = 1'b1;
        end
        // A new timeout outranks a simultaneous clear request.
        if (expired) begin
            tflag_d = 1'b1;
        end else if (clear_err) begin
            tflag_d = 1'b0;
        end
    end

    always_comb begin
        lda_go    = (state_q == ST_ISSUE);
        busy      = (state_q != ST_IDLE);
        req0_done = (state_q == ST_COMPLETE) && !owner_q;
        req1_done = (state_q == ST_COMPLETE) && owner_q;
        req0_err  = req0_done && err_q;
        req1_err  = req1_done && err_q;
    end

    assign timeout_flag  = tflag_q;
    assign lda_x0        = cmd_q[X0_LSB +: X0_W];
    assign lda_y0        = cmd_q[Y0_LSB +: Y0_W];
    assign lda_x1        = cmd_q[X1_LSB +: X1_W];
    assign lda_y1        = cmd_q[Y1_LSB +: Y1_W];
    assign lda_color     = cmd_q[COLOR_LSB +: COLOR_W];
    assign lda_thickness = cmd_q[THICK_LSB +: THICK_W];
    assign lda_base_addr = cmd_q[BASE_LSB +: BASE_W];

endmodule
